// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// (W1 wins on collision), write-to-read bypass, x0 hardwired to zero, sequential clear.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                w0_en,
  input  logic [AW-1:0]       w0_addr,
  input  logic [XLEN-1:0]     w0_data,
  input  logic                w1_en,
  input  logic [AW-1:0]       w1_addr,
  input  logic [XLEN-1:0]     w1_data,
  output logic                ready,
  output logic                wr_collide
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = '0;
  localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            ready_reg, ready_next;
  logic            clear_we;
  logic            run_wr;
  logic            w0_we;
  logic            w1_we;
  logic            same_waddr;

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= ONE_ADDR;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
    end
  end

  // Clear walks entries 1..NREGS-1 and then parks; cnt is held at the last entry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready_next = ready_reg;
    clear_we   = 1'b0;
    run_wr     = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clear_we = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_RUN;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE_ADDR;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          cnt_next   = ONE_ADDR;
          ready_next = 1'b0;
        end else begin
          run_wr = 1'b1;
        end
      end
    endcase
  end

  assign same_waddr = (w0_addr == w1_addr);
  assign wr_collide = w0_en && w1_en && same_waddr && (w0_addr != ZERO_ADDR);

  // W0 is suppressed outright on a collision so W1's value is the one stored.
  assign w0_we = run_wr && w0_en && (w0_addr != ZERO_ADDR) && !(w1_en && same_waddr);
  assign w1_we = run_wr && w1_en && (w1_addr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_we) begin
        mem[cnt_reg] <= '0;
      end else begin
        if (w0_we) mem[w0_addr] <= w0_data;
        if (w1_we) mem[w1_addr] <= w1_data;
      end
    end
  end

  assign ready = ready_reg;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   rd_a;
      logic [XLEN-1:0] rd_v;

      assign rd_a = rd_addr[gi*AW +: AW];

      always_comb begin
        rd_v = '0;
        if (rd_a == ZERO_ADDR || !ready_reg) begin
          rd_v = '0;
        end else if (w1_en && w1_addr == rd_a) begin
          rd_v = w1_data;
        end else if (w0_en && w0_addr == rd_a) begin
          rd_v = w0_data;
        end else begin
          rd_v = mem[rd_a];
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = rd_v;
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2-read/1-write 64x32 file. It provides NRD combinational read ports and two write ports (W0 for ALU writeback, W1 for load writeback), with same-cycle write-to-read bypass and an x0-hardwired-zero rule. Reset clears the array one entry per cycle, so the array can map onto RAM-style storage. A `ready` flag tells the pipeline when the clear has finished.

## Interface
- `XLEN`, 64, register width in bits
- `NREGS`, 32, number of architectural registers; power of two, >= 4
- `NRD`, 2, number of read ports, >= 1
- `AW`, $clog2(NREGS), address width; derived, not overridden

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `clear_req`  in  1  single-cycle pulse; starts a full array clear without reset
- `rd_addr`  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- `rd_data`  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN]
- `w0_en`, `w1_en`  in  1  write enables
- `w0_addr`, `w1_addr`  in  AW  write addresses
- `w0_data`, `w1_data`  in  XLEN  write data
- `ready`  out  1  registered; high when the array is usable
- `wr_collide`  out  1  combinational; high when `w0_en && w1_en && w0_addr == w1_addr && w0_addr != 0`

## Operation
- **States:** CLEAR and RUN, plus an internal clear counter `cnt[AW-1:0]`.
- **Reset:** on any edge with `reset` = 1, state goes to CLEAR, `cnt` = 1 and `ready` = 0. No entry is written while `reset` is held.
- **CLEAR (`reset` = 0):**
  - Each edge writes 0 to `reg[cnt]` and increments `cnt`.
  - On the edge that clears `reg[NREGS-1]`, state goes to RUN and `ready` goes to 1.
  - `cnt` never wraps.
- **RUN + `clear_req`:** state goes to CLEAR, `cnt` = 1, `ready` = 0 on that edge. Writes presented in that cycle are dropped.
  - `clear_req` during CLEAR is ignored; the sequence is not restarted.
- **Reset mid-clear:** restarts the sequence from `cnt` = 1.
- **Entry 0:** never written. It reads as 0 in every state.
- **Writes in RUN:**
  - On the edge, `reg[wN_addr]` <= `wN_data` for each enabled port with a nonzero address.
  - On a same-address collision, W1 wins and W0 is discarded.
  - Writes in CLEAR are ignored.
- **Reads (combinational, per port k), in priority order:**
  1. `rd_addr_k` == 0 -> 0.
  2. `ready` == 0 -> 0.
  3. `w1_en` && `w1_addr` == `rd_addr_k` -> `w1_data` (bypass).
  4. `w0_en` && `w0_addr` == `rd_addr_k` -> `w0_data` (bypass).
  5. Otherwise `reg[rd_addr_k]`.
- **Output reset values:**
  - `ready` = 0 after reset.
  - All `rd_data` = 0 while `ready` = 0.
  - `wr_collide` follows its inputs in every state.
- **Widths:** no arithmetic on data. Address compares are full AW bits.

## Timing
- Read latency is 0 cycles; bypass gives same-cycle visibility of a write.
- A write is visible from the array on the first read after its edge.
- Clear duration is NREGS-1 edges with `reset` low. For NREGS = 32, `ready` rises after the 31st edge following reset deassertion.
- `clear_req` drops `ready` on the edge where it is sampled. `ready` returns NREGS-1 edges later.

## Test plan
- **Reset clear:** hold `reset` 3 cycles, then release.
  - `ready` = 0 for exactly 31 edges and rises after the 31st.
  - Every address reads 0 throughout.
- **Write/readback and bypass:** in RUN, write x5 = 0xDEAD_BEEF_0000_0001 via W0.
  - Same cycle: `rd_addr[0]` = 5 returns the value via bypass.
  - Next cycle: it returns the value from the array.
- **x0 rule:** write x0 = 0xFFFF_FFFF_FFFF_FFFF via W1.
  - Port reads of address 0 return 0 in the write cycle and after it.
- **Collision:** W0 x7 = 0x11 and W1 x7 = 0x22 in one cycle.
  - `wr_collide` = 1, bypass read = 0x22, next-cycle read = 0x22.
  - Repeat with address 0: `wr_collide` = 0.
- **`clear_req` mid-run:** fill x1..x31 with their index values, then pulse `clear_req` together with a W0 write of x3 = 0x99.
  - The write is dropped and `ready` = 0 for 31 edges.
  - Afterwards all registers read 0.
- **Reset mid-clear:** assert `reset` for 1 cycle on the 10th clear edge.
  - `ready` rises 31 edges after that reset deasserts, not earlier.
